// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single memory_controller, with a read-return pipeline and chip-select hazard blocking.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: port A always wins ties. Otherwise, round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 9
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iReqA,
  input  logic              iWeA,
  input  logic              iCsA,
  input  logic [ADDR_W-1:0] iAddrA,
  input  logic [DATA_W-1:0] iDataA,
  output logic              oGntA,
  output logic [DATA_W-1:0] oRdDataA,
  output logic              oRdValidA,
  input  logic              iReqB,
  input  logic              iWeB,
  input  logic              iCsB,
  input  logic [ADDR_W-1:0] iAddrB,
  input  logic [DATA_W-1:0] iDataB,
  output logic              oGntB,
  output logic [DATA_W-1:0] oRdDataB,
  output logic              oRdValidB,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  output logic              oMemWren,
  output logic              oMemCs,
  input  logic [DATA_W-1:0] iMemQ
);

  logic              gnt_a, gnt_b, blk_a, blk_b, cand_a, cand_b, xfer;
  logic              win_we, win_cs;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              ret_a, ret_b;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  logic              mem_cs_q, mem_cs_d;
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
  logic              rd_vld_a_q, rd_vld_a_d, rd_vld_b_q, rd_vld_b_d;

  // Read-return stages: {valid, read, port (1 = B), cs}
  logic vld_p1_q, vld_p1_d, rd_p1_q, rd_p1_d, port_p1_q, port_p1_d, cs_p1_q, cs_p1_d;
  logic vld_p2_q, vld_p2_d, rd_p2_q, rd_p2_d, port_p2_q, port_p2_d, cs_p2_q, cs_p2_d;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic last_b_q, last_b_d;
`endif

  always_comb begin
    // A read in stage 1 pins chip-select until its data has been returned.
    blk_a  = vld_p1_q && rd_p1_q && (iCsA != cs_p1_q);
    blk_b  = vld_p1_q && rd_p1_q && (iCsB != cs_p1_q);
    cand_a = iReqA && !blk_a;
    cand_b = iReqB && !blk_b;
`ifdef MEM_ARB_FIXED_PRIO_EN
    gnt_a  = cand_a;
`else
    gnt_a  = cand_a && (!cand_b || last_b_q);
`endif
    gnt_b  = cand_b && !gnt_a;
    xfer   = gnt_a || gnt_b;

    win_we   = gnt_a ? iWeA   : iWeB;
    win_cs   = gnt_a ? iCsA   : iCsB;
    win_addr = gnt_a ? iAddrA : iAddrB;
    win_data = gnt_a ? iDataA : iDataB;

    mem_addr_d = xfer ? win_addr : mem_addr_q;
    mem_data_d = xfer ? win_data : mem_data_q;
    mem_cs_d   = xfer ? win_cs   : mem_cs_q;
    mem_wren_d = xfer && win_we;
`ifndef MEM_ARB_FIXED_PRIO_EN
    last_b_d   = xfer ? gnt_b : last_b_q;
`endif

    vld_p1_d  = xfer;
    rd_p1_d   = !win_we;
    port_p1_d = gnt_b;
    cs_p1_d   = win_cs;
    vld_p2_d  = vld_p1_q;
    rd_p2_d   = rd_p1_q;
    port_p2_d = port_p1_q;
    cs_p2_d   = cs_p1_q;

    ret_a       = vld_p2_q && rd_p2_q && !port_p2_q;
    ret_b       = vld_p2_q && rd_p2_q && port_p2_q;
    rd_vld_a_d  = ret_a;
    rd_vld_b_d  = ret_b;
    rd_data_a_d = ret_a ? iMemQ : rd_data_a_q;
    rd_data_b_d = ret_b ? iMemQ : rd_data_b_q;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_wren_q  <= 1'b0;
      mem_cs_q    <= 1'b0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_vld_a_q  <= 1'b0;
      rd_vld_b_q  <= 1'b0;
      vld_p1_q    <= 1'b0;
      rd_p1_q     <= 1'b0;
      port_p1_q   <= 1'b0;
      cs_p1_q     <= 1'b0;
      vld_p2_q    <= 1'b0;
      rd_p2_q     <= 1'b0;
      port_p2_q   <= 1'b0;
      cs_p2_q     <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_b_q    <= 1'b1;
`endif
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_wren_q  <= mem_wren_d;
      mem_cs_q    <= mem_cs_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_vld_a_q  <= rd_vld_a_d;
      rd_vld_b_q  <= rd_vld_b_d;
      vld_p1_q    <= vld_p1_d;
      rd_p1_q     <= rd_p1_d;
      port_p1_q   <= port_p1_d;
      cs_p1_q     <= cs_p1_d;
      vld_p2_q    <= vld_p2_d;
      rd_p2_q     <= rd_p2_d;
      port_p2_q   <= port_p2_d;
      cs_p2_q     <= cs_p2_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_b_q    <= last_b_d;
`endif
    end
  end

  assign oGntA     = gnt_a;
  assign oGntB     = gnt_b;
  assign oMemAddr  = mem_addr_q;
  assign oMemData  = mem_data_q;
  assign oMemWren  = mem_wren_q;
  assign oMemCs    = mem_cs_q;
  assign oRdDataA  = rd_data_a_q;
  assign oRdDataB  = rd_data_b_q;
  assign oRdValidA = rd_vld_a_q;
  assign oRdValidB = rd_vld_b_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory_controller between two requesters: port A (drawing/pixel writer) and port B (display/readback).
- Arbitrates one access per clock. Drives the controller's address, data, write-enable and chip-select. Returns read data to the owning port.
- Owns the read-return pipeline and the chip-select hazard: the controller's output mux follows the live chip-select, so chip-select must not change while a read is in flight.

Parameters:
- ADDR_W, 17, address width, matches controller iAddress.
- DATA_W, 9, data width, matches controller iData/oQ.

Ports:
- iClk  in  1  clock for the arbiter and the memory.
- iReset  in  1  asynchronous active-high reset.
- iReqA  in  1  port A request valid; held with payload until granted.
- iWeA  in  1  port A write (1) / read (0).
- iCsA  in  1  port A bank select (0 = bank 0, 1 = bank 1).
- iAddrA  in  ADDR_W  port A address.
- iDataA  in  DATA_W  port A write data.
- oGntA  out  1  combinational grant; transfer on the edge where iReqA && oGntA.
- oRdDataA  out  DATA_W  port A read data.
- oRdValidA  out  1  one-cycle pulse, oRdDataA valid.
- iReqB, iWeB, iCsB, iAddrB, iDataB, oGntB, oRdDataB, oRdValidB: same as the port A signals, for port B.
- oMemAddr  out  ADDR_W  to controller iAddress.
- oMemData  out  DATA_W  to controller iData.
- oMemWren  out  1  to controller iWren.
- oMemCs  out  1  to controller iChipSelect.
- iMemQ  in  DATA_W  from controller oQ.

Behaviour:
- Reset:
  - The clock is iClk; reset is iReset, asynchronous and active-high.
  - All registered outputs reset to 0: oMemAddr, oMemData, oMemWren, oMemCs, oRdData*, oRdValid*.
  - In-flight reads are discarded; no oRdValid is produced for them.
  - The round-robin pointer resets to "last = B", so A wins the first tie.
- Arbitration (combinational, per cycle):
  - Candidates are the ports with iReq=1 that are not hazard-blocked.
  - If one candidate, it is granted. If two, the port not granted most recently wins.
  - At most one oGnt is high. oGnt never depends on a port's own payload except iCs, which is used for the hazard check.
- Issue (edge E1, transfer edge):
  - oMemAddr/oMemData/oMemCs take the winner's payload.
  - oMemWren = winner's iWe.
  - The pointer updates to the winner.
- No transfer:
  - oMemWren = 0; oMemAddr/oMemData hold.
  - oMemCs holds its previous value (required for the hazard rule).
- Read pipeline:
  - The BRAM samples at E2; iMemQ is valid between E2 and E3.
  - At E3 the arbiter latches iMemQ into oRdData of the issuing port and pulses its oRdValid high for the cycle after E3.
  - Latency from transfer edge to oRdValid rising: 2 clocks.
  - Two stage regs carry {valid, read, port id, cs}.
- Hazard:
  - A read issued at edge E1 occupies stage1 during E1..E2.
  - A request whose iCs differs from the stage1 read's cs is blocked that cycle (its oGnt = 0).
  - If the other port's request is legal, it is granted; otherwise the cycle is a bubble with oMemCs held.
- Throughput:
  - Back-to-back accesses to the same bank are allowed every cycle, including read-after-read and write-after-read.
  - Writes never block chip-select changes.
- Simultaneous events:
  - A read return and a new issue in the same cycle are independent.
  - Both ports may have oRdValid in consecutive cycles; never in the same cycle.
- oRdData holds its value between pulses.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: port A always wins ties. The pointer is not used. A hazard-blocked A still yields to a legal B.
- Undefined: round-robin as above.

Test Plan:
- Reset, then A writes addr 0x00010, cs=0, data 0x1A5 -> oGntA=1 same cycle; next cycle oMemWren=1, oMemAddr=0x00010, oMemCs=0.
- A reads 0x00010, cs=0 -> oRdValidA pulses 2 clocks after the transfer edge with oRdDataA=0x1A5; oRdValidB stays 0.
- A and B both request reads, cs=0, for 4 cycles -> grants alternate A, B, A, B, starting with A; data returns in issue order to the correct ports.
  - With MEM_ARB_FIXED_PRIO_EN: A granted all 4 cycles.
- A reads cs=0, and the next cycle only B requests a read with cs=1 -> B stalled one cycle with oGntB=0 and oMemCs held at 0; B granted the cycle after. Both returns are correct: bank-0 data to A, bank-1 data to B.
- Write cs=1 followed immediately by read cs=0 -> no stall; the read returns bank-0 data.
- Assert iReset the cycle after a read transfer -> all outputs 0 asynchronously; no oRdValid after reset release; the next tie is granted to A.
